// File: rtl/imem_prog_loader.sv
// rtl/imem_prog_loader.sv - framed byte-stream loader for the instruction memory write port
// Holds the CPU in reset while an image streams in; releases it only after the checksum matches.
module imem_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_write_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_write_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR_LO = 3'd1;
  localparam logic [2:0] HDR_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CSUM   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERR    = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [31:0]       word_q, word_d;

  logic              byte_ready_q, byte_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic [15:0]       word_idx_ext;

  // byte_ready_q always mirrors state_q, so it is the handshake qualifier for this cycle
  assign accept       = byte_valid && byte_ready_q;
  assign word_idx_ext = 16'(word_idx_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    sum_d      = sum_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = HDR_LO;
          len_d      = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          sum_d      = '0;
        end
      end
      HDR_LO: begin
        if (accept) begin
          len_d[7:0] = byte_data;
          state_d    = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept) begin
          len_d[15:8] = byte_data;
          if (len_d == '0 || 32'(len_d) > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          sum_d      = sum_q + byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
            addr_d  = word_idx_q;
            wdata_d = word_d;
          end
        end
      end
      WRITE: begin
        if (word_idx_ext == len_q - 16'd1) begin
          state_d = CSUM;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = DATA;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (byte_data == sum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are decoded from the next state so they stay registered yet in step with it
    byte_ready_d = (state_d == HDR_LO) || (state_d == HDR_HI) ||
                   (state_d == DATA)   || (state_d == CSUM);
    busy_d       = (state_d != IDLE) && (state_d != DONE) && (state_d != ERR);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERR);
    cpu_rst_n_d  = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      sum_q        <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rst_n_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      sum_q        <= sum_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready      = byte_ready_q;
  assign imem_write_en   = we_q;
  assign imem_addr       = addr_q;
  assign imem_write_data = wdata_q;
  assign cpu_rst_n       = cpu_rst_n_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// tb/tb_imem_prog_loader.sv - scoreboard bench for imem_prog_loader
module tb_imem_prog_loader;

  localparam int          ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_write_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_write_data;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              error;

  imem_prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .imem_write_en   (imem_write_en),
    .imem_addr       (imem_addr),
    .imem_write_data (imem_write_data),
    .cpu_rst_n       (cpu_rst_n),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          t_start = 0;
  logic        we_prev = 1'b0;
  logic [41:0] sb_q[$];
  logic [7:0]  frame[$];
  logic [31:0] words[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && imem_write_en) begin
      wr_count <= wr_count + 1;
      check("strobe_1cyc", {31'b0, we_prev}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        check("wr_addr", 32'(imem_addr), 32'(sb_q[0][41:32]));
        check("wr_data", imem_write_data, sb_q[0][31:0]);
        sb_q.delete(0);
      end
    end
    we_prev <= imem_write_en;
  end

  task automatic build_frame(input int n, input logic bad_sum, input logic push);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        frame.push_back(b);
        sum = sum + b;
      end
      if (push) sb_q.push_back({ADDR_W'(i), words[i]});
    end
    frame.push_back(bad_sum ? sum + 8'd1 : sum);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic send_frame(input logic gaps);
    int g;
    int to;
    for (int i = 0; i < frame.size(); i++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      if (g > 0) byte_valid = 1'b0;
      repeat (g) begin
        start = ($urandom_range(0, 1) == 1);
        @(negedge clk);
      end
      start = 1'b0;
      byte_valid = 1'b1;
      byte_data = frame[i];
      to = 0;
      while (!byte_ready && to < 50) begin
        @(negedge clk);
        to++;
      end
      if (to >= 50) begin
        check("ready_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_end(output int t);
    int to;
    to = 0;
    while (!(done || error) && to < 300) begin
      @(negedge clk);
      to++;
    end
    if (to >= 300) check("end_timeout", 32'd1, 32'd0);
    t = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, byte_ready}, 32'd0);
    check({tag, "_we"}, {31'b0, imem_write_en}, 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_write_data, 32'd0);
    check({tag, "_cpu_rst_n"}, {31'b0, cpu_rst_n}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic cr);
    check({tag, "_done"}, {31'b0, done}, {31'b0, d});
    check({tag, "_error"}, {31'b0, error}, {31'b0, e});
    check({tag, "_cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, cr});
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_ready"}, {31'b0, byte_ready}, 32'd0);
    check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    int t;
    int w0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // N=2 reference image, continuous valid
    words = '{32'h0000_0013, 32'hDEAD_BEEF};
    build_frame(2, 1'b0, 1'b1);
    w0 = wr_count;
    do_start();
    check("start_ready", {31'b0, byte_ready}, 32'd1);
    check("start_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    check("start_busy", {31'b0, busy}, 32'd1);
    send_frame(1'b0);
    wait_end(t);
    check("n2_latency", t - t_start, 32'd13);
    check("n2_writes", wr_count - w0, 32'd2);
    check_status("n2", 1'b1, 1'b0, 1'b1);

    // Same image, bad checksum
    build_frame(2, 1'b1, 1'b1);
    w0 = wr_count;
    do_start();
    send_frame(1'b0);
    wait_end(t);
    check("badsum_writes", wr_count - w0, 32'd2);
    check_status("badsum", 1'b0, 1'b1, 1'b0);

    // Zero-length header
    frame = '{8'h00, 8'h00};
    w0 = wr_count;
    do_start();
    send_frame(1'b0);
    check("len0_writes", wr_count - w0, 32'd0);
    check_status("len0", 1'b0, 1'b1, 1'b0);

    // Length one past the limit
    frame = '{8'h01, 8'h04};
    w0 = wr_count;
    do_start();
    send_frame(1'b0);
    repeat (2) @(negedge clk);
    check("len1025_writes", wr_count - w0, 32'd0);
    check_status("len1025", 1'b0, 1'b1, 1'b0);

    // N=3 random words, gappy valid, stray start pulses
    words = '{$urandom, $urandom, $urandom};
    build_frame(3, 1'b0, 1'b1);
    w0 = wr_count;
    do_start();
    send_frame(1'b1);
    wait_end(t);
    check("n3_writes", wr_count - w0, 32'd3);
    check_status("n3", 1'b1, 1'b0, 1'b1);

    // Reset asserted mid-DATA of word 1
    words = '{32'h0000_0013, 32'hDEAD_BEEF};
    build_frame(2, 1'b0, 1'b0);
    frame = frame[0:7];
    sb_q.push_back({ADDR_W'(0), 32'h0000_0013});
    do_start();
    send_frame(1'b0);
    check("mid_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check("partial_sb_empty", sb_q.size(), 32'd0);
    @(negedge clk);
    build_frame(2, 1'b0, 1'b1);
    w0 = wr_count;
    do_start();
    send_frame(1'b0);
    wait_end(t);
    check("reload_writes", wr_count - w0, 32'd2);
    check_status("reload", 1'b1, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
